// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and constants for the cache miss fill controller.
// Optional build macro: CRITICAL_WORD_FIRST_EN (see cache_fill_ctrl.sv).
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    META = 2'd2,
    DONE = 2'd3
  } fill_state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  localparam int WORDS_PER_BLOCK_DEF = 8;
  localparam int MEM_LATENCY_DEF     = 4;
  localparam int ADDR_W_DEF          = 16;
  localparam int DATA_W_DEF          = 16;

  localparam int OFFSET_W    = $clog2(WORDS_PER_BLOCK_DEF);
  localparam int BLOCK_BYTES = WORDS_PER_BLOCK_DEF * DATA_W_DEF / 8;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Miss, memory-port and fill-side signals of the cache fill controller.
// master = the controller, slave = caches + memory around it.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
);
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);

  logic              icache_miss;
  logic [ADDR_W-1:0] icache_miss_addr;
  logic              dcache_miss;
  logic [ADDR_W-1:0] dcache_miss_addr;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] fill_data;
  logic [OFF_W-1:0]  fill_word;
  logic              fill_data_we;
  logic              fill_meta_we;
  logic              fill_sel_d;
  logic              icache_stall;
  logic              dcache_stall;
  logic              fill_done;

  modport master (
    input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
           mem_data_valid, mem_data_in,
    output mem_en, mem_addr, fill_data, fill_word, fill_data_we,
           fill_meta_we, fill_sel_d, icache_stall, dcache_stall, fill_done
  );

  modport slave (
    output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
           mem_data_valid, mem_data_in,
    input  mem_en, mem_addr, fill_data, fill_word, fill_data_we,
           fill_meta_we, fill_sel_d, icache_stall, dcache_stall, fill_done
  );
endinterface

// File: rtl/cache_fill_ctrl_fill_word_counter.sv
// Wrapping word-offset counter: loads a start offset, then counts the
// number of steps taken; the offset wraps inside the block.
module fill_word_counter #(
  parameter int OFF_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OFF_W-1:0] start,
  input  logic             inc,
  output logic [OFF_W-1:0] off,
  output logic [OFF_W:0]   cnt
);
  logic [OFF_W-1:0] start_q;

  // Load the start offset while idle, then count steps during the fill
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
      cnt     <= '0;
    end else if (load) begin
      start_q <= start;
      cnt     <= '0;
    end else if (inc) begin
      cnt <= cnt + (OFF_W+1)'(1);
    end
  end

  assign off = start_q + cnt[OFF_W-1:0];
endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss fill controller for the I- and D-caches sharing one pipelined
// memory read port. D misses win over simultaneous I misses. A fill issues
// one word read per cycle, writes returned words into the owning cache's
// data array, strobes its metadata write, then pulses fill_done.
// Build macro CRITICAL_WORD_FIRST_EN: start the fill at the missed word and
// wrap around the block; undefined, fills always start at word 0.
module cache_fill_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  parameter int MEM_LATENCY     = MEM_LATENCY_DEF,
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF
) (
  input logic              clk,
  input logic              rst,
  cache_fill_ctrl_if.master bus
);
  localparam int OFF_W   = $clog2(WORDS_PER_BLOCK);
  localparam int BYTE_W  = $clog2(DATA_W / 8);
  localparam int BLK_LSB = OFF_W + BYTE_W;
  localparam int CNT_W   = OFF_W + 1;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam logic CWF_ON = 1'b1;
`else
  localparam logic CWF_ON = 1'b0;
`endif

  if (MEM_LATENCY < 1 || (1 << OFF_W) != WORDS_PER_BLOCK) begin : g_param_chk
    $error("cache_fill_ctrl: bad MEM_LATENCY or WORDS_PER_BLOCK");
  end

  fill_state_e               state, state_nxt;
  logic                      owner;
  logic [ADDR_W-1:BLK_LSB]   blk_base;
  logic [ADDR_W-1:BLK_LSB]   blk_sel;
  logic [OFF_W-1:0]          start_off;
  logic [OFF_W-1:0]          iss_off, ret_off;
  logic [CNT_W-1:0]          iss_cnt, ret_cnt;
  logic                      miss_any, accept, in_idle, iss_inc, ret_inc;

  assign miss_any = bus.dcache_miss | bus.icache_miss;
  assign in_idle  = (state == IDLE);
  assign accept   = in_idle & miss_any;
  assign blk_sel  = bus.dcache_miss ? bus.dcache_miss_addr[ADDR_W-1:BLK_LSB]
                                    : bus.icache_miss_addr[ADDR_W-1:BLK_LSB];
  assign start_off = (bus.dcache_miss ? bus.dcache_miss_addr[BLK_LSB-1:BYTE_W]
                                      : bus.icache_miss_addr[BLK_LSB-1:BYTE_W])
                     & {OFF_W{CWF_ON}};

  assign iss_inc = (state == FILL) & ~iss_cnt[OFF_W];
  assign ret_inc = (state == FILL) & bus.mem_data_valid;

  fill_word_counter #(.OFF_W(OFF_W)) u_iss_cnt (
    .clk(clk), .rst(rst), .load(in_idle), .start(start_off),
    .inc(iss_inc), .off(iss_off), .cnt(iss_cnt)
  );

  fill_word_counter #(.OFF_W(OFF_W)) u_ret_cnt (
    .clk(clk), .rst(rst), .load(in_idle), .start(start_off),
    .inc(ret_inc), .off(ret_off), .cnt(ret_cnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Record which cache owns the fill when a miss is accepted
  always_ff @(posedge clk) begin
    if (rst)         owner <= OWNER_I;
    else if (accept) owner <= bus.dcache_miss ? OWNER_D : OWNER_I;
  end

  // Block address of the accepted miss
  always_ff @(posedge clk) begin
    if (accept) blk_base <= blk_sel;
  end

  // Next state and fill/memory-port outputs; stalls track misses during reset
  always_comb begin
    state_nxt         = state;
    bus.mem_en        = 1'b0;
    bus.mem_addr      = '0;
    bus.fill_data     = '0;
    bus.fill_word     = '0;
    bus.fill_data_we  = 1'b0;
    bus.fill_meta_we  = 1'b0;
    bus.fill_done     = 1'b0;
    bus.fill_sel_d    = 1'b0;
    bus.icache_stall  = bus.icache_miss;
    bus.dcache_stall  = bus.dcache_miss;
    if (!rst) begin
      bus.icache_stall = bus.icache_miss | (!in_idle && owner == OWNER_I);
      bus.dcache_stall = bus.dcache_miss | (!in_idle && owner == OWNER_D);
      bus.fill_sel_d   = !in_idle && owner == OWNER_D;
      case (state)
        IDLE: begin
          if (miss_any) state_nxt = FILL;
        end
        FILL: begin
          if (iss_inc) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = {blk_base, iss_off, {BYTE_W{1'b0}}};
          end
          bus.fill_data    = bus.mem_data_in;
          bus.fill_word    = ret_off;
          bus.fill_data_we = bus.mem_data_valid;
          if (bus.mem_data_valid && ret_cnt == CNT_W'(WORDS_PER_BLOCK - 1))
            state_nxt = META;
        end
        META: begin
          bus.fill_meta_we = 1'b1;
          state_nxt        = DONE;
        end
        DONE: begin
          bus.fill_done = 1'b1;
          state_nxt     = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Miss-handling controller for the 2-way, 64-set I-cache and D-cache (16-byte blocks, 8 x 16-bit words). It arbitrates I- and D-cache misses onto the single pipelined memory port and issues 8 sequential word reads. It steers the returned words into the selected cache's data array, then pulses that cache's metadata write (tag/valid/LRU) into the victim way. Stall signals to the pipeline are held until the fill completes.

Parameters:
WORDS_PER_BLOCK, 8, words per cache block (power of 2)
MEM_LATENCY, 4, cycles from mem_en to mem_data_valid for that request
ADDR_W, 16, byte address width
DATA_W, 16, word width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
icache_miss  in  1  level; I-cache lookup missed, held until serviced
icache_miss_addr  in  ADDR_W  byte address of I miss
dcache_miss  in  1  level; D-cache lookup missed, held until serviced
dcache_miss_addr  in  ADDR_W  byte address of D miss
mem_en  out  1  memory read request this cycle
mem_addr  out  ADDR_W  word-aligned read address
mem_data_valid  in  1  returned word valid
mem_data_in  in  DATA_W  returned word
fill_data  out  DATA_W  word to write into data array
fill_word  out  log2(WORDS_PER_BLOCK)  word offset within block
fill_data_we  out  1  data-array write strobe
fill_meta_we  out  1  one-cycle metadata write strobe (cache writes tag, valid=1, way LRU update)
fill_sel_d  out  1  1 = D-cache is fill target, 0 = I-cache
icache_stall  out  1  hold fetch
dcache_stall  out  1  hold memory stage
fill_done  out  1  one-cycle pulse at end of fill

Behaviour:
- States: IDLE, FILL, META, DONE.
- Reset: state=IDLE, counters=0. All outputs 0, except that icache_stall/dcache_stall follow their miss inputs combinationally. Reset in any state aborts the fill and returns to IDLE next edge. mem_data_valid is ignored in IDLE, META and DONE.
- IDLE: if dcache_miss, latch owner=D and base={dcache_miss_addr[ADDR_W-1:4],4'b0}. Else if icache_miss, owner=I. Either case -> FILL. D has fixed priority on simultaneous misses.
- FILL issue side: issue counter iss 0..7. mem_en=1 for 8 consecutive cycles starting the first FILL cycle. mem_addr = base + 2*iss (mod 16 within the block).
- FILL return side: return counter ret 0..7 advances on each mem_data_valid. fill_data=mem_data_in, fill_word=ret, fill_data_we=mem_data_valid, same cycle, no registering. When ret==7 and mem_data_valid -> META.
- Early mem_data_valid (before the first issue + MEM_LATENCY) is a protocol error. No recovery is required.
- META: fill_meta_we=1 for exactly one cycle. The tag comes from the cache's own latched miss address; the controller only strobes it. -> DONE.
- DONE: fill_done=1 for one cycle -> IDLE. The owning cache re-looks-up and hits, so its miss drops. A miss still high in IDLE is serviced again; this is legal and harmless.
- fill_sel_d=owner, valid in FILL/META/DONE. It is 0 in IDLE.
- icache_stall = icache_miss | (state!=IDLE & owner==I).
- dcache_stall = dcache_miss | (state!=IDLE & owner==D).
- A non-owner miss arriving mid-fill waits, stalled, and is serviced from IDLE after DONE.
- Latency, default params: miss seen in IDLE at cycle 0; issues cycles 1-8; returns cycles 5-12; META cycle 13; fill_done cycle 14.

Optional Feature:
CRITICAL_WORD_FIRST_EN:
- Defined: the starting offset s=miss_addr[3:1] is latched. Issue order is s, s+1, ... wrapping mod 8, with fill_word following the same wrapped sequence. Completion is still after 8 returns.
- Undefined: the start offset is always 0.

Decomposition:
- Package cache_ctrl_pkg: state enum (IDLE/FILL/META/DONE), OWNER_I=0/OWNER_D=1, OFFSET_W=log2(WORDS_PER_BLOCK), BLOCK_BYTES.
- One sub-module, fill_word_counter: holds the wrapping issue and return counters with start-offset load. It is instantiated once for issue and once for return.

Test Plan:
- D miss addr 0x1236 -> mem_addr 0x1230,0x1232..0x123E on cycles 1-8; fill_data_we cycles 5-12 with fill_word 0..7; fill_meta_we cycle 13; fill_done cycle 14; fill_sel_d=1 throughout.
- I and D miss same cycle (I 0x0040, D 0x2000) -> D filled first (0x2000..0x200E), icache_stall high throughout; I fill of 0x0040 starts the cycle after D's fill_done.
- I miss 0x00A0 alone -> 8 issues 0x00A0..0x00AE, fill_sel_d=0, dcache_stall stays 0 with dcache_miss low.
- rst asserted during FILL after 3 returns -> next cycle IDLE, no fill_meta_we or fill_done. Remaining mem_data_valid pulses produce no fill_data_we.
- With CRITICAL_WORD_FIRST_EN, D miss 0x123A -> mem_addr 0x123A,0x123C,0x123E,0x1230..0x1238; fill_word 5,6,7,0,1,2,3,4.
- Miss held high after fill_done -> second fill is issued from IDLE; the bench checks identical addresses and a correct second completion.
